// File: rtl/ascon_ctrl.sv
// rtl/ascon_ctrl.sv - Ascon-128 encryption sequencer: round counter, datapath selects, AD/PT handshakes.
module ascon_ctrl #(
  parameter int ROUND_WIDTH = 4,
  parameter int PA_ROUNDS   = 12,
  parameter int PB_ROUNDS   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   no_ad_i,
  input  logic                   ad_valid_i,
  input  logic                   ad_last_i,
  output logic                   ad_ready_o,
  input  logic                   pt_valid_i,
  input  logic                   pt_last_i,
  output logic                   pt_ready_o,
  output logic                   en_state_o,
  output logic                   sel_ad_o,
  output logic                   sel_state_init_o,
  output logic                   sel_xor_init_o,
  output logic                   sel_xor_ext_o,
  output logic                   sel_xor_dom_sep_o,
  output logic                   sel_xor_fin_o,
  output logic                   sel_xor_tag_o,
  output logic                   ct_valid_o,
  output logic                   tag_valid_o,
  output logic [ROUND_WIDTH-1:0] rnd_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {IDLE, INIT, AD, PT, FIN, DONE} state_t;

  localparam logic [ROUND_WIDTH-1:0] RC_LAST  = ROUND_WIDTH'(PA_ROUNDS - 1);
  localparam logic [ROUND_WIDTH-1:0] RC_BLOCK = ROUND_WIDTH'(PA_ROUNDS - PB_ROUNDS);

  state_t                 state, state_nxt;
  logic [ROUND_WIDTH-1:0] rc, rc_nxt;
  logic                   no_ad, no_ad_nxt;
  logic                   ad_last, ad_last_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rc      <= '0;
      no_ad   <= 1'b0;
      ad_last <= 1'b0;
    end else begin
      state   <= state_nxt;
      rc      <= rc_nxt;
      no_ad   <= no_ad_nxt;
      ad_last <= ad_last_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    rc_nxt            = rc;
    no_ad_nxt         = no_ad;
    ad_last_nxt       = ad_last;
    ad_ready_o        = 1'b0;
    pt_ready_o        = 1'b0;
    en_state_o        = 1'b0;
    sel_ad_o          = 1'b0;
    sel_state_init_o  = 1'b0;
    sel_xor_init_o    = 1'b0;
    sel_xor_ext_o     = 1'b0;
    sel_xor_dom_sep_o = 1'b0;
    sel_xor_fin_o     = 1'b0;
    sel_xor_tag_o     = 1'b0;
    ct_valid_o        = 1'b0;
    tag_valid_o       = 1'b0;
    rnd_o             = '0;
    busy_o            = (state != IDLE);
    done_o            = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = INIT;
          rc_nxt    = '0;
          no_ad_nxt = no_ad_i;
        end
      end
      INIT: begin
        en_state_o       = 1'b1;
        rnd_o            = rc;
        sel_state_init_o = (rc == '0);
        if (rc == RC_LAST) begin
          sel_xor_init_o    = 1'b1;
          sel_xor_dom_sep_o = no_ad;
          state_nxt         = no_ad ? PT : AD;
          rc_nxt            = RC_BLOCK;
        end else begin
          rc_nxt = rc + 1'b1;
        end
      end
      AD: begin
        sel_ad_o = 1'b1;
        rnd_o    = rc;
        if (rc == RC_BLOCK) begin
          // Block entry: the state only advances once a block is actually absorbed.
          ad_ready_o = 1'b1;
          if (ad_valid_i) begin
            en_state_o    = 1'b1;
            sel_xor_ext_o = 1'b1;
            ad_last_nxt   = ad_last_i;
            rc_nxt        = rc + 1'b1;
          end
        end else begin
          en_state_o = 1'b1;
          if (rc == RC_LAST) begin
            rc_nxt = RC_BLOCK;
            if (ad_last) begin
              sel_xor_dom_sep_o = 1'b1;
              state_nxt         = PT;
            end
          end else begin
            rc_nxt = rc + 1'b1;
          end
        end
      end
      PT: begin
        rnd_o = rc;
        if (rc == RC_BLOCK) begin
          pt_ready_o = 1'b1;
          if (pt_valid_i) begin
            en_state_o    = 1'b1;
            sel_xor_ext_o = 1'b1;
            ct_valid_o    = 1'b1;
            if (pt_last_i) begin
              // Final block doubles as finalization round 0.
              sel_xor_fin_o = 1'b1;
              rnd_o         = '0;
              state_nxt     = FIN;
              rc_nxt        = ROUND_WIDTH'(1);
            end else begin
              rc_nxt = rc + 1'b1;
            end
          end
        end else begin
          en_state_o = 1'b1;
          rc_nxt     = (rc == RC_LAST) ? RC_BLOCK : rc + 1'b1;
        end
      end
      FIN: begin
        en_state_o = 1'b1;
        rnd_o      = rc;
        if (rc == RC_LAST) begin
          sel_xor_tag_o = 1'b1;
          state_nxt     = DONE;
          rc_nxt        = '0;
        end else begin
          rc_nxt = rc + 1'b1;
        end
      end
      DONE: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        rc_nxt    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl.sv
// tb/tb_ascon_ctrl.sv - Scoreboard bench for ascon_ctrl: per-cycle expected control words vs DUT.
module tb_ascon_ctrl;

  logic       clk;
  logic       rst;
  logic       start_i, no_ad_i;
  logic       ad_valid_i, ad_last_i, ad_ready_o;
  logic       pt_valid_i, pt_last_i, pt_ready_o;
  logic       en_state_o, sel_ad_o, sel_state_init_o, sel_xor_init_o;
  logic       sel_xor_ext_o, sel_xor_dom_sep_o, sel_xor_fin_o, sel_xor_tag_o;
  logic       ct_valid_o, tag_valid_o, busy_o, done_o;
  logic [3:0] rnd_o;

  ascon_ctrl #(.ROUND_WIDTH(4), .PA_ROUNDS(12), .PB_ROUNDS(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .no_ad_i(no_ad_i),
    .ad_valid_i(ad_valid_i), .ad_last_i(ad_last_i), .ad_ready_o(ad_ready_o),
    .pt_valid_i(pt_valid_i), .pt_last_i(pt_last_i), .pt_ready_o(pt_ready_o),
    .en_state_o(en_state_o), .sel_ad_o(sel_ad_o), .sel_state_init_o(sel_state_init_o),
    .sel_xor_init_o(sel_xor_init_o), .sel_xor_ext_o(sel_xor_ext_o),
    .sel_xor_dom_sep_o(sel_xor_dom_sep_o), .sel_xor_fin_o(sel_xor_fin_o),
    .sel_xor_tag_o(sel_xor_tag_o), .ct_valid_o(ct_valid_o), .tag_valid_o(tag_valid_o),
    .rnd_o(rnd_o), .busy_o(busy_o), .done_o(done_o)
  );

  localparam logic [17:0] BUSY  = 18'h20000;
  localparam logic [17:0] DONE  = 18'h10000;
  localparam logic [17:0] TAGV  = 18'h08000;
  localparam logic [17:0] CTV   = 18'h04000;
  localparam logic [17:0] ADRDY = 18'h02000;
  localparam logic [17:0] PTRDY = 18'h01000;
  localparam logic [17:0] EN    = 18'h00800;
  localparam logic [17:0] SAD   = 18'h00400;
  localparam logic [17:0] SINIT = 18'h00200;
  localparam logic [17:0] XINIT = 18'h00100;
  localparam logic [17:0] EXT   = 18'h00080;
  localparam logic [17:0] DSEP  = 18'h00040;
  localparam logic [17:0] FIN   = 18'h00020;
  localparam logic [17:0] TAG   = 18'h00010;

  logic [17:0] obs;
  assign obs = {busy_o, done_o, tag_valid_o, ct_valid_o, ad_ready_o, pt_ready_o, en_state_o,
                sel_ad_o, sel_state_init_o, sel_xor_init_o, sel_xor_ext_o, sel_xor_dom_sep_o,
                sel_xor_fin_o, sel_xor_tag_o, rnd_o};

  typedef struct {
    int          cyc;
    logic [17:0] w;
  } exp_t;

  exp_t sb[$];
  int   cyc, checks, errors;
  int   np, stall_left, pt_cnt, done_cnt;
  int   start_a, start_b, rst_at, cut_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] rn(int r);
    return 18'(r);
  endfunction

  function automatic void push(int c, logic [17:0] w);
    if (cut_cyc < 0 || c <= cut_cyc) sb.push_back('{c, w});
  endfunction

  // Expected timeline of one operation started in cycle t, built block by block from the latency rules.
  task automatic build(int t, int na, int npb, int stall);
    int c;
    logic [17:0] w;
    c = t + 1;
    for (int r = 0; r < 12; r++) begin
      w = BUSY | EN | rn(r);
      if (r == 0) w |= SINIT;
      if (r == 11) begin
        w |= XINIT;
        if (na == 0) w |= DSEP;
      end
      push(c++, w);
    end
    for (int b = 0; b < na; b++) begin
      for (int r = 6; r < 12; r++) begin
        w = BUSY | EN | SAD | rn(r);
        if (r == 6) w |= ADRDY | EXT;
        if (r == 11 && b == na - 1) w |= DSEP;
        push(c++, w);
      end
    end
    for (int p = 0; p < npb; p++) begin
      if (p == 0)
        for (int s = 0; s < stall; s++) push(c++, BUSY | PTRDY | rn(6));
      if (p < npb - 1) begin
        for (int r = 6; r < 12; r++) begin
          w = BUSY | EN | rn(r);
          if (r == 6) w |= PTRDY | EXT | CTV;
          push(c++, w);
        end
      end else begin
        push(c++, BUSY | PTRDY | EXT | CTV | FIN | EN);
        for (int r = 1; r < 12; r++) begin
          w = BUSY | EN | rn(r);
          if (r == 11) w |= TAG;
          push(c++, w);
        end
      end
    end
    push(c++, BUSY | DONE | TAGV);
    for (int i = 0; i < 3; i++) push(c++, '0);
  endtask

  task automatic step();
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (obs === e.w) else begin
        errors++;
        $error("FAIL ctrl cyc=%0d observed=%h expected=%h", e.cyc, obs, e.w);
      end
    end
    if (done_o === 1'b1) done_cnt++;
    if (pt_valid_i && pt_ready_o === 1'b1) pt_cnt++;
    if (!pt_valid_i && pt_ready_o === 1'b1 && stall_left > 0) stall_left--;
    @(posedge clk);
    #1;
    cyc++;
    pt_last_i  = (pt_cnt == np - 1);
    pt_valid_i = (stall_left == 0);
    start_i    = (cyc == start_a) || (cyc == start_b);
    rst        = (cyc < 2) || (cyc == rst_at);
  endtask

  task automatic run(string tag);
    int budget;
    budget = 200;
    while (sb.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s timeout: pending=%0d required=0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic launch(int na, int npb, int stall, int pa, int pb, int ra, int cut);
    int t;
    t          = cyc;
    np         = npb;
    pt_cnt     = 0;
    done_cnt   = 0;
    stall_left = stall;
    pt_valid_i = (stall == 0);
    pt_last_i  = (npb == 1);
    no_ad_i    = (na == 0);
    ad_last_i  = 1'b1;
    start_i    = 1'b1;
    start_a    = (pa < 0) ? -1 : t + pa;
    start_b    = (pb < 0) ? -1 : t + pb;
    rst_at     = (ra < 0) ? -1 : t + ra;
    cut_cyc    = (cut < 0) ? -1 : t + cut;
    build(t, na, npb, stall);
    if (cut >= 0) begin
      cut_cyc = -1;
      for (int i = 1; i <= 3; i++) push(t + cut + i, '0);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    np = 1; stall_left = 0; pt_cnt = 0; done_cnt = 0;
    start_a = -1; start_b = -1; rst_at = -1; cut_cyc = -1;
    rst = 1'b1; start_i = 1'b0; no_ad_i = 1'b0;
    ad_valid_i = 1'b1; ad_last_i = 1'b1; pt_valid_i = 1'b1; pt_last_i = 1'b1;
    #1;

    for (int c = 1; c <= 4; c++) push(c, '0);
    run("reset");

    launch(0, 1, 0, -1, -1, -1, -1);
    run("no_ad_1pt");

    launch(1, 2, 0, -1, -1, -1, -1);
    run("1ad_2pt");

    launch(0, 1, 3, -1, -1, -1, -1);
    run("pt_stall");

    launch(1, 1, 0, 14, 25, -1, -1);
    run("start_ignored");
    checks++;
    assert (done_cnt == 1) else begin
      errors++;
      $error("FAIL done_count observed=%0d expected=1", done_cnt);
    end

    launch(0, 1, 0, -1, -1, 18, 18);
    run("rst_in_fin");
    checks++;
    assert (done_cnt == 0) else begin
      errors++;
      $error("FAIL rst_done_count observed=%0d expected=0", done_cnt);
    end

    launch(0, 1, 0, -1, -1, -1, -1);
    run("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_ctrl.md
Name: ascon_ctrl

Overview:
Sequencing FSM for the Ascon-128 round datapath (one round per cycle, 64-bit rate) during authenticated encryption. It drives every select/enable line of the datapath and supplies its round index. It also runs valid/ready handshakes with the associated-data (AD) and plaintext (PT) sources, and signals busy/done to the host. Inputs arrive already padded and block-aligned; padding is done upstream.

Parameters:
ROUND_WIDTH, 4, width of rnd_o
PA_ROUNDS, 12, rounds for initialization and finalization (p^a)
PB_ROUNDS, 6, rounds per AD/PT block (p^b); block rounds use indices PA_ROUNDS-PB_ROUNDS .. PA_ROUNDS-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  begin an operation (honoured only in IDLE)
no_ad_i  in  1  sampled with start_i; 1 = no AD blocks
ad_valid_i / ad_last_i  in  1/1  AD block present / final AD block
ad_ready_o  out  1  AD accepted when valid&ready
pt_valid_i / pt_last_i  in  1/1  PT block present / final PT block
pt_ready_o  out  1  PT accepted when valid&ready
en_state_o, sel_ad_o, sel_state_init_o, sel_xor_init_o, sel_xor_ext_o, sel_xor_dom_sep_o, sel_xor_fin_o, sel_xor_tag_o  out  1 each  datapath controls
ct_valid_o  out  1  ciphertext word valid this cycle
tag_valid_o  out  1  tag valid this cycle
rnd_o  out  ROUND_WIDTH  round index to datapath
busy_o  out  1  high outside IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Registered state: FSM state, round counter rc, no_ad flag. All outputs are combinational from state/rc, gated by valid where noted. In IDLE every output is 0 and rnd_o=0.
- States: IDLE, INIT, AD, PT, FIN, DONE.
- IDLE: start_i=1 -> INIT, rc=0, latch no_ad_i. Otherwise stay.
- INIT: en_state=1, rnd_o=rc.
  - rc=0: sel_state_init=1.
  - rc=PA-1: sel_xor_init=1. If no_ad is set, sel_xor_dom_sep=1 in the same cycle.
  - Exit after rc=PA-1: to AD with rc=PA-PB if no_ad=0, else to PT with rc=PA-PB.
- AD, first cycle (rc=PA-PB):
  - ad_ready=1 and sel_ad=1.
  - If ad_valid=0: en_state=0, sel_xor_ext=0, rc holds (stall, indefinite).
  - If ad_valid=1: en_state=1, sel_xor_ext=1, ad_last latched, rc++.
- AD, other rounds: en_state=1, sel_ad=1, rc++.
  - rc=PA-1 with latched last=1: sel_xor_dom_sep=1, then -> PT.
  - rc=PA-1 with last=0: -> AD with rc=PA-PB.
- PT, first cycle (rc=PA-PB):
  - pt_ready=1. If pt_valid=0: stall as in AD.
  - If pt_valid=1 and pt_last=0: en_state, sel_xor_ext and ct_valid all 1; run PB rounds; after rc=PA-1 -> PT first cycle.
  - If pt_valid=1 and pt_last=1: -> FIN this same cycle. FIN cycle 0 is this cycle: sel_xor_ext, ct_valid, sel_xor_fin and en_state all 1, rnd_o=0. Next cycle rc=1.
- FIN: en_state=1, rnd_o=rc for rc=0..PA-1. At rc=PA-1: sel_xor_tag=1. Then -> DONE.
- DONE, exactly one cycle: tag_valid=1, done_o=1, busy=1, en_state=0. Then -> IDLE.
- Control rules:
  - sel_xor_ext is never high without a completed handshake.
  - ready is never high outside a block's first cycle.
  - ready does not depend on valid.
- Boundaries:
  - start_i outside IDLE is ignored.
  - ad_last_i/pt_last_i are sampled only on a transfer.
  - rc never exceeds PA-1.
  - rst at any cycle: IDLE on the next edge, all outputs 0, rc=0, no pending transfer.
- Latency with no stalls, start_i at cycle T:
  - INIT: T+1..T+12.
  - Each AD block: 6 cycles. Each non-final PT block: 6 cycles.
  - Final PT + FIN: 12 cycles, then DONE.
  - Example: 1 AD + 1 PT gives done_o at T+31.

Test Plan:
- no_ad=1, one PT (last) valid throughout, start at T:
  - sel_state_init at T+1.
  - sel_xor_init and dom_sep together at T+12.
  - ext/ct_valid/fin at T+13, sel_xor_tag at T+24.
  - tag_valid and done at T+25; IDLE at T+26.
- 1 AD (last) + 2 PT:
  - sel_ad high T+13..T+18; dom_sep at T+18.
  - ct_valid at T+19 and T+25; done at T+37.
  - rnd_o sequence 6..11 per block.
- pt_valid low 3 cycles at PT first cycle: pt_ready=1 and en_state=0 for 3 cycles, rc holds 6, sel_xor_ext=0; resumes on the 4th cycle; done shifts by 3.
- start_i pulsed during AD and FIN: no state change, done count is 1.
- rst asserted at FIN rc=5: next cycle IDLE, busy=0, all controls 0; a fresh start then completes normally.
- Integrated with the datapath: key=nonce=000102..0F, no AD, PT final block 8000000000000000 -> ct and tag match the Ascon-128 golden model.
